// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side streaming path.
// Default widths/depths and the beat-counter width rule live here.
package fifo_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int OBUF_DEPTH  = 2;
  localparam int PKT_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 16;

  typedef logic [1:0] obuf_cnt_t;

  // A 1- or 2-beat packet still needs one bit of counter state.
  function automatic int beat_cnt_w(input int pkt_len);
    return (pkt_len <= 2) ? 1 : $clog2(pkt_len);
  endfunction

  localparam int BEAT_W_DEF = beat_cnt_w(PKT_LEN_DEF);

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer holding {last,data}; push and pop may coincide.
// A push into a full buffer is accepted only when a pop frees a slot the same cycle.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output obuf_cnt_t    count_o
);

  logic [W-1:0] mem_q [OBUF_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  obuf_cnt_t    count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    rd_ptr_d = rd_ptr_q ^ do_pop;
    wr_ptr_d = wr_ptr_q ^ do_push;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port into a valid/ready byte stream with packet framing.
// Read credit keeps buffered + in-flight bytes at two or fewer, so a ready sink gets one beat per cycle.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  beats_out,
  output logic              idle
);

  localparam int                BEAT_W    = beat_cnt_w(PKT_LEN);
  localparam logic [BEAT_W:0]   PKT_LEN_X = (BEAT_W+1)'(PKT_LEN);
  localparam logic [BEAT_W:0]   LAST_X    = (BEAT_W+1)'(PKT_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_IDX  = BEAT_W'(PKT_LEN - 1);

  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  obuf_cnt_t         count;
  logic [DATA_W:0]   head;
  logic [DATA_W:0]   push_entry;
  logic              pop;
  logic              push_last;
  logic [2:0]        credit_use;
  logic [BEAT_W:0]   push_idx;

  assign pop        = m_valid & m_ready;
  assign credit_use = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = enable & ~fifo_empty & (credit_use < 3'd2);

  // The landing byte sits behind `count` entries, so its packet index is beat_cnt + count.
  always_comb begin
    push_idx  = {1'b0, beat_cnt_q} + (BEAT_W+1)'(count);
    push_last = 1'b0;
    if (PKT_LEN == 1) begin
      push_last = 1'b1;
    end else if (push_idx >= PKT_LEN_X) begin
      push_last = ((push_idx - PKT_LEN_X) == LAST_X);
    end else begin
      push_last = (push_idx == LAST_X);
    end
  end

  assign push_entry = {push_last, fifo_data};

  always_comb begin
    inflight_d = fifo_rd_en & ~fifo_empty;
    beat_cnt_d = beat_cnt_q;
    beats_d    = beats_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + 1'b1;
      beats_d    = beats_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      beats_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
      beats_q    <= beats_d;
    end
  end

  fifo_out_buf #(
    .W (DATA_W + 1)
  ) u_obuf (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign m_valid   = (count != 2'd0);
  assign m_data    = head[DATA_W-1:0];
  assign m_last    = m_valid & head[DATA_W];
  assign beats_out = beats_q;
  assign idle      = (count == 2'd0) & ~inflight_q & fifo_empty;

  assert property (@(posedge clk) disable iff (!reset_n)
    (({1'b0, count} + {2'b00, inflight_q}) <= 3'd2));

  assert property (@(posedge clk) disable iff (!reset_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: two readers (PKT_LEN 16 and 4) share stimulus, each behind its own 16x8 FIFO model.
// A queue-based reference tracks every written byte until it is handed to the sink.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic m_ready = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic        fifo_empty [2];
  logic [7:0]  fifo_data  [2];
  logic        fifo_rd_en [2];
  logic        m_valid    [2];
  logic [7:0]  m_data     [2];
  logic        m_last     [2];
  logic [15:0] beats_out  [2];
  logic        idle       [2];

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(8), .PKT_LEN(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_rd_en(fifo_rd_en[0]), .m_valid(m_valid[0]),
    .m_data(m_data[0]), .m_last(m_last[0]), .m_ready(m_ready),
    .beats_out(beats_out[0]), .idle(idle[0]));

  fifo_stream_reader #(.DATA_W(8), .PKT_LEN(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_rd_en(fifo_rd_en[1]), .m_valid(m_valid[1]),
    .m_data(m_data[1]), .m_last(m_last[1]), .m_ready(m_ready),
    .beats_out(beats_out[1]), .idle(idle[1]));

  int total = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] fmem [2][16];
  int fwp [2];
  int frp [2];
  int fcnt [2];

  int hs [2];
  int lastn [2];
  int rd_pulses [2];
  logic [7:0] last_data [2];
  logic [7:0] last_hs_data [2];
  logic prev_stall [2];
  logic [7:0] prev_data [2];
  logic prev_last [2];

  function automatic int pl(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void q_push(input int i, input logic [7:0] d);
    if (i == 0) q0.push_back(d);
    else q1.push_back(d);
  endfunction

  function automatic logic [7:0] q_pop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty[0] = (fcnt[0] == 0);
  assign fifo_empty[1] = (fcnt[1] == 0);

  // 16x8 FIFO model with a registered read port; writes also enter the reference queue.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fwp[i] <= 0;
        frp[i] <= 0;
        fcnt[i] <= 0;
        fifo_data[i] <= 8'h00;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en && fcnt[i] < 16) begin
          fmem[i][fwp[i]] <= wr_data;
          fwp[i] <= (fwp[i] + 1) % 16;
          q_push(i, wr_data);
        end
        if (fifo_rd_en[i] && fcnt[i] != 0) begin
          fifo_data[i] <= fmem[i][frp[i]];
          frp[i] <= (frp[i] + 1) % 16;
        end
        fcnt[i] <= fcnt[i] + ((wr_en && fcnt[i] < 16) ? 1 : 0)
                           - ((fifo_rd_en[i] && fcnt[i] != 0) ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        hs[i] = 0;
        lastn[i] = 0;
        prev_stall[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_rd_en[i]) rd_pulses[i]++;
        chk("rd_while_empty", {31'b0, fifo_rd_en[i] & fifo_empty[i]}, 32'd0);
        chk("beats_out", {16'b0, beats_out[i]}, hs[i] & 32'hffff);
        chk("idle", {31'b0, idle[i]}, {31'b0, q_size(i) == 0});
        if (prev_stall[i]) begin
          chk("stall_valid", {31'b0, m_valid[i]}, 32'd1);
          chk("stall_data", {24'b0, m_data[i]}, {24'b0, prev_data[i]});
          chk("stall_last", {31'b0, m_last[i]}, {31'b0, prev_last[i]});
        end
        if (m_valid[i] && m_ready) begin
          if (q_size(i) == 0) begin
            chk("beat_without_byte", {31'b0, m_valid[i]}, 32'd0);
          end else begin
            chk("m_data", {24'b0, m_data[i]}, {24'b0, q_pop(i)});
            chk("m_last", {31'b0, m_last[i]}, {31'b0, (hs[i] % pl(i)) == pl(i) - 1});
          end
          if (m_last[i]) begin
            lastn[i]++;
            last_data[i] = m_data[i];
          end
          last_hs_data[i] = m_data[i];
          hs[i]++;
        end
        prev_stall[i] = m_valid[i] && !m_ready;
        prev_data[i] = m_data[i];
        prev_last[i] = m_last[i];
      end
    end
  end

  task automatic drv_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic smp_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    drv_cycle();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(idle[0] && idle[1] && q0.size() == 0 && q1.size() == 0) && n < budget) begin
      smp_cycle();
      n++;
    end
    chk(name, {31'b0, idle[0] && idle[1] && q0.size() == 0 && q1.size() == 0}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cyc;
    int v_cyc;
    int n;
    int sent;

    for (int i = 0; i < 2; i++) begin
      rd_pulses[i] = 0;
      last_data[i] = 8'h00;
      last_hs_data[i] = 8'h00;
    end
    repeat (3) drv_cycle();
    reset_n = 1'b1;
    smp_cycle();
    for (int i = 0; i < 2; i++) begin
      chk("rst_m_valid", {31'b0, m_valid[i]}, 32'd0);
      chk("rst_m_data", {24'b0, m_data[i]}, 32'd0);
      chk("rst_m_last", {31'b0, m_last[i]}, 32'd0);
      chk("rst_beats_out", {16'b0, beats_out[i]}, 32'd0);
      chk("rst_idle", {31'b0, idle[i]}, 32'd1);
      chk("rst_rd_en", {31'b0, fifo_rd_en[i]}, 32'd0);
    end

    // Prefilled 16 bytes, then enable: latency 2, one beat per cycle.
    drv_cycle();
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) write_byte(8'(k));
    enable = 1'b1;
    n = 0;
    do begin smp_cycle(); n++; end while (!fifo_rd_en[0] && n < 20);
    rd_cyc = cyc;
    n = 0;
    while (!m_valid[0] && n < 20) begin smp_cycle(); n++; end
    v_cyc = cyc;
    chk("first_latency", 32'(v_cyc - rd_cyc), 32'd2);
    n = 0;
    while (beats_out[0] != 16'd16 && n < 40) begin smp_cycle(); n++; end
    chk("t1_throughput", 32'(cyc - v_cyc), 32'd16);
    wait_idle("t1_idle", 40);
    chk("t1_last_count", 32'(lastn[0]), 32'd1);
    chk("t1_last_byte", {24'b0, last_data[0]}, 32'h10);
    chk("t1_pkt4_lasts", 32'(lastn[1]), 32'd4);

    // PKT_LEN=4 framing across a gap.
    drv_cycle();
    for (int k = 0; k < 10; k++) write_byte(8'hA0 + 8'(k));
    wait_idle("t2_idle", 40);
    chk("t2_last_count", 32'(lastn[1]), 32'd6);
    chk("t2_last_byte", {24'b0, last_data[1]}, 32'hA7);
    drv_cycle();
    write_byte(8'hAA);
    write_byte(8'hAB);
    wait_idle("t2b_idle", 40);
    chk("t2b_last_count", 32'(lastn[1]), 32'd7);
    chk("t2b_last_byte", {24'b0, last_data[1]}, 32'hAB);
    chk("t2b_pkt16_lasts", 32'(lastn[0]), 32'd1);

    // Sink stalled with five bytes queued.
    drv_cycle();
    enable = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) write_byte(8'h30 + 8'(k));
    enable = 1'b1;
    rd_pulses[0] = 0;
    repeat (10) smp_cycle();
    chk("t3_rd_pulses", 32'(rd_pulses[0]), 32'd2);
    chk("t3_fifo_left", 32'(fcnt[0]), 32'd3);
    chk("t3_head", {24'b0, m_data[0]}, 32'h30);
    drv_cycle();
    m_ready = 1'b1;
    wait_idle("t3_idle", 40);
    chk("t3_beats", {16'b0, beats_out[0]}, 32'd33);

    // 50 random bytes against a sink alternating ready.
    drv_cycle();
    sent = 0;
    n = 0;
    while (sent < 50 && n < 2000) begin
      m_ready = ~m_ready;
      if (fcnt[0] < 15) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom_range(0, 255));
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      drv_cycle();
      n++;
    end
    wr_en = 1'b0;
    n = 0;
    while (!(idle[0] && idle[1] && q0.size() == 0 && q1.size() == 0) && n < 400) begin
      m_ready = ~m_ready;
      drv_cycle();
      n++;
    end
    m_ready = 1'b1;
    wait_idle("t4_idle", 20);
    chk("t4_beats", {16'b0, beats_out[0]}, 32'd83);

    // enable drops the cycle after a read is issued.
    drv_cycle();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) write_byte(8'h50 + 8'(k));
    enable = 1'b1;
    rd_pulses[0] = 0;
    drv_cycle();
    enable = 1'b0;
    repeat (8) smp_cycle();
    chk("t5_rd_pulses", 32'(rd_pulses[0]), 32'd1);
    chk("t5_beats", {16'b0, beats_out[0]}, 32'd84);
    chk("t5_landed", {24'b0, last_hs_data[0]}, 32'h50);
    chk("t5_fifo_left", 32'(fcnt[0]), 32'd2);
    drv_cycle();
    enable = 1'b1;
    wait_idle("t5_idle", 40);
    chk("t5_beats_final", {16'b0, beats_out[0]}, 32'd86);

    // Reset with two bytes buffered.
    drv_cycle();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) write_byte(8'h60 + 8'(k));
    repeat (6) drv_cycle();
    chk("t6_pre_valid", {31'b0, m_valid[0]}, 32'd1);
    chk("t6_pre_fifo", 32'(fcnt[0]), 32'd2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t6_async_valid", {31'b0, m_valid[i]}, 32'd0);
      chk("t6_async_beats", {16'b0, beats_out[i]}, 32'd0);
    end
    drv_cycle();
    drv_cycle();
    reset_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) write_byte(8'h70 + 8'(k));
    wait_idle("t6_idle", 40);
    chk("t6_beats", {16'b0, beats_out[1]}, 32'd5);
    chk("t6_last_count", 32'(lastn[1]), 32'd1);
    chk("t6_last_byte", {24'b0, last_data[1]}, 32'h73);
    chk("t6_pkt16_lasts", 32'(lastn[0]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
